// File: rtl/point_op_acc_if.sv
// ---------------------------------------------------------------------------
// point_op_acc_if
// Word-memory bus between the point-operation accelerator and the shared
// single-port memory.
//   addr   : word address (master -> memory)
//   dataW  : write data (master -> memory)
//   en     : request strobe (master -> memory)
//   we     : 1 = write, 0 = read, meaningful only with en=1 (master -> memory)
//   dataR  : read data, valid the cycle after a read request (memory -> master)
// ---------------------------------------------------------------------------
interface point_op_acc_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] dataW;
  logic [WORD_W-1:0] dataR;
  logic              en;
  logic              we;

  modport master (
    output addr,
    output dataW,
    output en,
    output we,
    input  dataR
  );

  modport slave (
    input  addr,
    input  dataW,
    input  en,
    input  we,
    output dataR
  );
endinterface

// File: rtl/point_op_acc.sv
// ---------------------------------------------------------------------------
// point_op_acc
// Streams an N_WORDS-word packed greyscale image from SRC_BASE to DST_BASE
// over a shared single-port word memory, applying a per-pixel operation
// chosen at start: invert, binary threshold, saturating offset, or copy.
// One word is moved every two cycles (READ, then WRITE).
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset
//   i_start  : level; a run begins when sampled high in IDLE
//   i_mode   : 00 invert, 01 threshold, 10 offset, 11 copy (latched at start)
//   i_param  : threshold (unsigned) or offset (two's complement), latched
//   mem      : memory bus (master modport)
//   o_busy   : high in READ and WRITE
//   o_finish : high in DONE
// ---------------------------------------------------------------------------
module point_op_acc #(
  parameter int ADDR_W   = 16,
  parameter int WORD_W   = 32,
  parameter int PIX_W    = 8,
  parameter int N_WORDS  = 25344,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 25344
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [PIX_W-1:0]   i_param,
  point_op_acc_if.master     mem,
  output logic               o_busy,
  output logic               o_finish
);

  localparam int LANES = WORD_W / PIX_W;
  localparam int IDX_W = $clog2(N_WORDS + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
  localparam logic [PIX_W-1:0]  PIX_MAX  = {PIX_W{1'b1}};

  localparam logic [1:0] MODE_INVERT = 2'b00;
  localparam logic [1:0] MODE_THRESH = 2'b01;
  localparam logic [1:0] MODE_OFFSET = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [1:0]        r_mode;
  logic [1:0]        w_mode_nxt;
  logic [PIX_W-1:0]  r_param;
  logic [PIX_W-1:0]  w_param_nxt;
  logic [WORD_W-1:0] w_op_word;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;

  // Per-pixel operation. The offset sum is formed in PIX_W+2 bits so that
  // the top bit is the sign and the next bit flags overflow above MAX.
  function automatic logic [PIX_W-1:0] pix_op(
    input logic [1:0]       op,
    input logic [PIX_W-1:0] prm,
    input logic [PIX_W-1:0] p
  );
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] res;
    sum = {2'b00, p} + {{2{prm[PIX_W-1]}}, prm};
    res = p;
    case (op)
      MODE_INVERT: res = PIX_MAX - p;
      MODE_THRESH: begin
        if (p >= prm) begin
          res = PIX_MAX;
        end else begin
          res = {PIX_W{1'b0}};
        end
      end
      MODE_OFFSET: begin
        if (sum[PIX_W+1]) begin
          res = {PIX_W{1'b0}};
        end else if (sum[PIX_W]) begin
          res = PIX_MAX;
        end else begin
          res = sum[PIX_W-1:0];
        end
      end
      default: res = p;
    endcase
    return res;
  endfunction

  // Word addresses wrap modulo 2^ADDR_W.
  assign w_src_addr = SRC_A + ADDR_W'(r_idx);
  assign w_dst_addr = DST_A + ADDR_W'(r_idx);

  // Lane-wise transform of the word returned by the preceding READ.
  always_comb begin
    w_op_word = {WORD_W{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      w_op_word[PIX_W*k +: PIX_W] = pix_op(r_mode, r_param, mem.dataR[PIX_W*k +: PIX_W]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word counter and operation settings captured at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= {IDX_W{1'b0}};
      r_mode  <= 2'b00;
      r_param <= {PIX_W{1'b0}};
    end else begin
      r_idx   <= w_idx_nxt;
      r_mode  <= w_mode_nxt;
      r_param <= w_param_nxt;
    end
  end

  // Next-state and output decode. Outputs depend only on the state register
  // (and dataR in WRITE), so an asynchronous reset drops them immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_param_nxt = r_param;
    mem.addr    = {ADDR_W{1'b0}};
    mem.dataW   = {WORD_W{1'b0}};
    mem.en      = 1'b0;
    mem.we      = 1'b0;
    o_busy      = 1'b0;
    o_finish    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_mode_nxt  = i_mode;
          w_param_nxt = i_param;
          w_idx_nxt   = {IDX_W{1'b0}};
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_READ: begin
        mem.en      = 1'b1;
        mem.addr    = w_src_addr;
        o_busy      = 1'b1;
        w_state_nxt = S_WRITE;
      end

      S_WRITE: begin
        mem.en    = 1'b1;
        mem.we    = 1'b1;
        mem.addr  = w_dst_addr;
        mem.dataW = w_op_word;
        o_busy    = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_ONE;
          w_state_nxt = S_READ;
        end
      end

      S_DONE: begin
        o_finish = 1'b1;
        // A held start must not retrigger; wait for it to drop.
        if (i_start) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_point_op_acc.sv
// ---------------------------------------------------------------------------
// tb_point_op_acc
// Self-checking bench for point_op_acc with N_WORDS=4, SRC_BASE=0,
// DST_BASE=16 and a 1-cycle-latency behavioural RAM.
// ---------------------------------------------------------------------------
module tb_point_op_acc;

  localparam int NW  = 4;
  localparam int SRC = 0;
  localparam int DST = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  param = 8'h00;
  logic        o_busy;
  logic        o_finish;

  logic [31:0] mem [0:31];
  logic [31:0] rdata = 32'h0;
  logic        ld_we = 1'b0;
  logic [4:0]  ld_addr = 5'd0;
  logic [31:0] ld_data = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  point_op_acc_if #(.ADDR_W(16), .WORD_W(32)) bus ();

  point_op_acc #(
    .ADDR_W(16), .WORD_W(32), .PIX_W(8),
    .N_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (start),
    .i_mode   (mode),
    .i_param  (param),
    .mem      (bus),
    .o_busy   (o_busy),
    .o_finish (o_finish)
  );

  initial forever #5 clk = ~clk;

  // Behavioural RAM: one-cycle read latency, bench loads take priority.
  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (bus.en && bus.we) mem[bus.addr[4:0]] <= bus.dataW;
    if (bus.en && !bus.we) rdata <= mem[bus.addr[4:0]];
  end
  assign bus.dataR = rdata;

  // Reference: each pixel computed with plain integer arithmetic.
  function automatic logic [31:0] ref_word(input logic [1:0] m, input logic [7:0] prm,
                                           input logic [31:0] w);
    logic [31:0] res;
    int p, r, sp;
    res = 32'h0;
    sp = int'(prm);
    if (sp >= 128) sp = sp - 256;
    for (int k = 0; k < 4; k++) begin
      p = int'((w >> (8 * k)) & 32'hFF);
      case (m)
        2'd0: r = 255 - p;
        2'd1: r = (p >= int'(prm)) ? 255 : 0;
        2'd2: begin
          r = p + sp;
          if (r < 0) r = 0;
          if (r > 255) r = 255;
        end
        default: r = p;
      endcase
      res[8*k +: 8] = r[7:0];
    end
    return res;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mem_write(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1'b1;
    ld_addr = a[4:0];
    ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic load_image(input logic [31:0] s [4]);
    for (int i = 0; i < NW; i++) mem_write(SRC + i, s[i]);
    for (int i = 0; i < NW; i++) mem_write(DST + i, 32'hA5A5_0000 + i);
  endtask

  // One run: start, follow the bus cycle by cycle, check timing and handshake.
  task automatic do_run(input logic [1:0] m, input logic [7:0] p, input bit hold, input bit perturb);
    int busy_n, fin_cyc, idx;
    bit seq_ok, done_ok;
    logic exp_we;
    logic [15:0] exp_addr;
    @(negedge clk);
    start = 1'b1; mode = m; param = p;
    @(posedge clk);
    busy_n = 0; fin_cyc = 0; seq_ok = 1'b1;
    for (int cyc = 1; cyc <= 40 && fin_cyc == 0; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (o_busy) begin
        idx = busy_n / 2;
        exp_we = (busy_n % 2) == 1;
        exp_addr = exp_we ? 16'(DST + idx) : 16'(SRC + idx);
        if (!(bus.en === 1'b1 && bus.we === exp_we && bus.addr === exp_addr)) seq_ok = 1'b0;
        busy_n++;
      end else if (bus.en !== 1'b0 || bus.we !== 1'b0) begin
        seq_ok = 1'b0;
      end
      if (o_finish === 1'b1) fin_cyc = cyc;
      if (perturb && cyc == 3) begin mode = ~m; param = ~p; end
    end
    check32("busy_cycles", 32'(busy_n), 32'd8);
    check32("finish_cycle", 32'(fin_cyc), 32'd9);
    check32("bus_sequence", {31'h0, seq_ok}, 32'd1);
    if (hold) begin
      done_ok = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (!(o_finish === 1'b1 && o_busy === 1'b0 && bus.en === 1'b0)) done_ok = 1'b0;
      end
      check32("held_start_stays_done", {31'h0, done_ok}, 32'd1);
      start = 1'b0;
    end
    @(negedge clk);
    check32("back_to_idle", {30'h0, o_finish, o_busy}, 32'd0);
  endtask

  task automatic check_dst(input string name, input logic [1:0] m, input logic [7:0] p,
                           input logic [31:0] s [4]);
    for (int i = 0; i < NW; i++) check32(name, mem[DST + i], ref_word(m, p, s[i]));
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  param;
    logic [31:0] src0;
    logic [31:0] exp0;
  } vec_t;

  vec_t vecs [5];
  logic [31:0] img [4];

  initial begin
    vecs[0] = '{2'b00, 8'h00, 32'h00FF7F01, 32'hFF0080FE};
    vecs[1] = '{2'b01, 8'h80, 32'h7F80FF00, 32'h00FFFF00};
    vecs[2] = '{2'b10, 8'h20, 32'hF0100005, 32'hFF302025};
    vecs[3] = '{2'b10, 8'hF0, 32'hF0100005, 32'hE0000000};
    vecs[4] = '{2'b11, 8'h5A, 32'h12345678, 32'h12345678};

    // Reset state.
    #12;
    check32("reset_outputs", {bus.en, bus.we, o_busy, o_finish, 12'h0, bus.addr}, 32'h0);
    check32("reset_dataW", bus.dataW, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("idle_outputs", {bus.en, bus.we, o_busy, o_finish, 12'h0, bus.addr}, 32'h0);

    // Table-driven fixed vectors.
    for (int v = 0; v < 5; v++) begin
      img[0] = vecs[v].src0;
      for (int i = 1; i < NW; i++) img[i] = $urandom;
      load_image(img);
      do_run(vecs[v].mode, vecs[v].param, 1'b0, 1'b0);
      check32("table_word0", mem[DST], vecs[v].exp0);
      check_dst("table_model", vecs[v].mode, vecs[v].param, img);
    end

    // Held start plus mid-run mode/param change.
    for (int i = 0; i < NW; i++) img[i] = $urandom;
    load_image(img);
    do_run(2'b00, 8'h33, 1'b1, 1'b1);
    check_dst("latched_settings", 2'b00, 8'h33, img);

    // Reset during the WRITE of word 2.
    for (int i = 0; i < NW; i++) img[i] = $urandom;
    load_image(img);
    @(negedge clk);
    start = 1'b1; mode = 2'b00; param = 8'h00;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check32("pre_reset_is_W2", {15'h0, bus.en, bus.we, bus.addr[14:0]}, {15'h0, 1'b1, 1'b1, 15'd18});
    reset = 1'b1;
    #1;
    check32("reset_midrun_bus", {bus.en, bus.we, o_busy, o_finish, 12'h0, bus.addr}, 32'h0);
    check32("reset_midrun_dataW", bus.dataW, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check32("reset_kept_w16", mem[DST + 0], ref_word(2'b00, 8'h00, img[0]));
    check32("reset_kept_w17", mem[DST + 1], ref_word(2'b00, 8'h00, img[1]));
    check32("reset_no_w18", mem[DST + 2], 32'hA5A5_0002);
    check32("reset_no_w19", mem[DST + 3], 32'hA5A5_0003);
    do_run(2'b00, 8'h00, 1'b0, 1'b0);
    check_dst("after_reset_run", 2'b00, 8'h00, img);

    // Back-to-back copy then invert on the same source.
    for (int i = 0; i < NW; i++) img[i] = $urandom;
    load_image(img);
    do_run(2'b11, 8'h00, 1'b0, 1'b0);
    check_dst("b2b_copy", 2'b11, 8'h00, img);
    do_run(2'b00, 8'h00, 1'b0, 1'b0);
    check_dst("b2b_invert", 2'b00, 8'h00, img);

    // Randomized runs against the reference model.
    for (int t = 0; t < 16; t++) begin
      logic [1:0] rm;
      logic [7:0] rp;
      rm = 2'($urandom_range(0, 3));
      rp = 8'($urandom);
      for (int i = 0; i < NW; i++) img[i] = $urandom;
      load_image(img);
      do_run(rm, rp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_dst("random_run", rm, rp, img);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
